store_buffer: RTL

//   Posted-write buffer between the EX/MEM pipeline register and data_mem (single port, comb read).

---
 rtl/store_buffer.sv | 96 +++++++++
 1 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer : posted-write queue in front of a single-port data memory,
//                with youngest-match store-to-load forwarding.
// Revision     : 1.0
// ============================================================================
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_write,
  input  logic                     mem_read,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     stall,
  output logic                     empty,
  output logic                     dm_write_en,
  output logic [ADDRESS_WIDTH-1:0] dm_addr,
  output logic [DATA_WIDTH-1:0]    dm_data_in,
  input  logic [DATA_WIDTH-1:0]    dm_data_out
);

  localparam int C_PTR_W = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic [C_PTR_W-1:0]       r_head;
  logic [C_PTR_W-1:0]       r_tail;
  logic [C_PTR_W:0]         r_count;

  logic                     w_full;
  logic                     w_push;
  logic                     w_drain;
  logic                     w_hit;
  logic [DATA_WIDTH-1:0]    w_fwd;
  logic [C_PTR_W-1:0]       w_idx;

  assign w_full  = (r_count == (C_PTR_W+1)'(DEPTH));
  assign w_push  = mem_write & ~mem_read & ~w_full;
  // A full queue drains even while a store waits, so the stall lasts one cycle.
  assign w_drain = ~mem_read & (r_count != '0) & (~mem_write | w_full);

  // Scan oldest to youngest; the last hit wins, giving youngest-match forwarding.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + C_PTR_W'(i);
      if (((C_PTR_W+1)'(i) < r_count) &&
          (r_addr[w_idx][ADDRESS_WIDTH-1:2] == addr[ADDRESS_WIDTH-1:2])) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= addr;
        r_data[r_tail] <= wdata;
        r_tail         <= r_tail + C_PTR_W'(1);
      end
      if (w_drain) begin
        r_head <= r_head + C_PTR_W'(1);
      end
      if (w_push) begin
        r_count <= r_count + (C_PTR_W+1)'(1);
      end else if (w_drain) begin
        r_count <= r_count - (C_PTR_W+1)'(1);
      end
    end
  end

  assign stall       = mem_write & ~mem_read & w_full;
  assign empty       = (r_count == '0);
  assign dm_write_en = w_drain;
  assign dm_addr     = mem_read ? addr : (w_drain ? r_addr[r_head] : '0);
  assign dm_data_in  = w_drain ? r_data[r_head] : '0;
  assign rdata       = mem_read ? (w_hit ? w_fwd : dm_data_out) : '0;

endmodule
`default_nettype wire
